vslc_prog_store: RTL and testbench

Program store for the VSLC core: a register-based instruction memory that answers the core's address-strobe fetch requests and is loaded by an external host over a 3-wire serial link. It is the responder to the core's fetch port: the core drives an address and `addr_strobe`, and this block returns the instruction byte. It sits beside the core inside the top-level wrapper. The load pins map to dedicated inputs and the fetch data feeds the core's program-data input.

---
 rtl/vslc_pkg.sv | 15 +
 rtl/vslc_sync2.sv | 27 ++
 rtl/vslc_prog_store.sv | 169 ++++++++++++++++
 tb/tb_vslc_prog_store.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vslc_pkg.sv
// Shared definitions for the VSLC program store: memory geometry, NOP opcode
// and the host-load FSM state type.
package vslc_pkg;

  localparam int         VSLC_PROG_DEPTH = 32;
  localparam int         VSLC_PROG_AW    = 5;
  localparam logic [7:0] VSLC_OP_NOP     = 8'h00;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_ADDR = 2'd1,
    LD_DATA = 2'd2
  } vslc_ld_state_t;

endpackage

// File: rtl/vslc_sync2.sv
// Two-flop synchroniser with a selectable reset value, for bringing the host
// load pins into the clk domain.
module vslc_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/vslc_prog_store.sv
// VSLC program store: flop-based instruction memory answering core fetches,
// loaded over a 3-wire host link. Define VSLC_PROG_READBACK_EN for ld_miso readback.
//
//   state   | meaning
//   LD_IDLE | no frame; core may fetch
//   LD_ADDR | shifting in the 8-bit load address
//   LD_DATA | shifting in data bytes, write + auto-increment every 8 bits
module vslc_prog_store
  import vslc_pkg::*;
#(
  parameter int DEPTH = VSLC_PROG_DEPTH,
  parameter int AW    = VSLC_PROG_AW
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       addr_strobe,
  input  logic [7:0] addr,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       hold_core,
  input  logic       ld_cs_n,
  input  logic       ld_sck,
  input  logic       ld_mosi,
  output logic       ld_miso
);

  localparam logic [8:0]    DEPTH_W  = 9'(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic cs_s, sck_s, mosi_s;

  vslc_sync2 #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(ld_cs_n), .q(cs_s));
  vslc_sync2 #(.RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .rst_n(rst_n), .d(ld_sck),  .q(sck_s));
  vslc_sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(ld_mosi), .q(mosi_s));

  vslc_ld_state_t state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [6:0]     shift_q, shift_d;
  logic [AW-1:0]  ptr_q, ptr_d, ptr_next;
  logic [7:0]     mem_q [DEPTH];
  logic [7:0]     mem_d [DEPTH];
  logic [7:0]     rdata_q, rdata_d, rd_word;
  logic           rvalid_q, rvalid_d;
  logic           sck_prev_q, cs_prev_q;
  logic [1:0]     warm_q, warm_d;
  logic           armed_q, armed_d;
  logic           sck_rise, cs_fall, cs_rise, wr_en;
  logic [7:0]     rx_byte;

  // The cs_n synchroniser leaves reset high; if the host holds cs_n low across
  // reset that would look like a fresh falling edge. Only arm frame detection
  // once cs_n has been genuinely observed high after the synchroniser settles.
  assign warm_d  = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
  assign armed_d = armed_q | ((warm_q == 2'd2) & cs_s);

  assign sck_rise = sck_s & ~sck_prev_q;
  assign cs_fall  = armed_q & cs_prev_q & ~cs_s;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign rx_byte  = {shift_q, mosi_s};
  assign ptr_next = (ptr_q == PTR_LAST) ? '0 : ptr_q + AW'(1);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    wr_en     = 1'b0;
    if (cs_rise) begin
      state_d = LD_IDLE;
    end else begin
      case (state_q)
        LD_IDLE: begin
          if (cs_fall) begin
            state_d   = LD_ADDR;
            bit_cnt_d = '0;
          end
        end
        LD_ADDR, LD_DATA: begin
          if (sck_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == LD_ADDR) begin
                ptr_d   = rx_byte[AW-1:0];
                state_d = LD_DATA;
              end else begin
                wr_en = 1'b1;
                ptr_d = ptr_next;
              end
            end
          end
        end
        default: state_d = LD_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[ptr_q] = rx_byte;
  end

  // Reads come from mem_q, so a same-edge write is not visible to the fetch.
  always_comb begin
    rd_word  = ({1'b0, addr} < DEPTH_W) ? mem_q[addr[AW-1:0]] : VSLC_OP_NOP;
    rvalid_d = addr_strobe;
    rdata_d  = addr_strobe ? rd_word : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LD_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      rdata_q    <= VSLC_OP_NOP;
      rvalid_q   <= 1'b0;
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b1;
      warm_q     <= '0;
      armed_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= VSLC_OP_NOP;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      sck_prev_q <= sck_s;
      cs_prev_q  <= cs_s;
      warm_q     <= warm_d;
      armed_q    <= armed_d;
      mem_q      <= mem_d;
    end
  end

  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign hold_core = (state_q != LD_IDLE);

`ifdef VSLC_PROG_READBACK_EN
  logic [7:0] sout_q, sout_d;
  logic       rb_load, sck_fall;

  assign sck_fall = ~sck_s & sck_prev_q;
  assign rb_load  = sck_rise & ~cs_rise & (bit_cnt_q == 3'd7) & (state_q != LD_IDLE);

  // No shift on the fall that follows a byte boundary, so the MSB of a freshly
  // loaded byte is still on ld_miso when the host samples the next sck rise.
  always_comb begin
    sout_d = sout_q;
    if (rb_load)
      sout_d = mem_d[ptr_d];
    else if (sck_fall && state_q == LD_DATA && bit_cnt_q != 3'd0)
      sout_d = {sout_q[6:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sout_q <= '0;
    else        sout_q <= sout_d;
  end

  assign ld_miso = sout_q[7];
`else
  assign ld_miso = 1'b0;
`endif

endmodule

// File: tb/tb_vslc_prog_store.sv
// Scoreboard bench for vslc_prog_store: random host frames and fetches checked
// against an array model of the program memory.
module tb_vslc_prog_store;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       addr_strobe = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] rdata;
  logic       rvalid;
  logic       hold_core;
  logic       ld_cs_n = 1'b1;
  logic       ld_sck = 1'b0;
  logic       ld_mosi = 1'b0;
  logic       ld_miso;

  int errors = 0;
  int checks = 0;

  logic [7:0] model [32];
  logic [7:0] exp_q [$];

  vslc_prog_store dut (
    .clk(clk), .rst_n(rst_n), .addr_strobe(addr_strobe), .addr(addr),
    .rdata(rdata), .rvalid(rvalid), .hold_core(hold_core),
    .ld_cs_n(ld_cs_n), .ld_sck(ld_sck), .ld_mosi(ld_mosi), .ld_miso(ld_miso)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rvalid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: rdata %h with no fetch outstanding", rdata);
      end else begin
        chk("fetch", rdata, exp_q.pop_front());
      end
    end
  end

  function automatic logic [7:0] exp_of(input logic [7:0] a);
    return (a < 8'd32) ? model[a[4:0]] : 8'h00;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fetch(input logic [7:0] a);
    addr = a;
    addr_strobe = 1'b1;
    exp_q.push_back(exp_of(a));
    cyc(1);
    addr_strobe = 1'b0;
    cyc(1);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] rb);
    rb = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      ld_mosi = b[i];
      cyc(1);
      rb[i] = ld_miso;
      ld_sck = 1'b1;
      cyc(6);
      ld_sck = 1'b0;
      cyc(6);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d [$]);
    logic [7:0] rb;
    int p;
    p = a % 32;
    ld_cs_n = 1'b0;
    cyc(6);
    send_bits(a, 8, rb);
    foreach (d[i]) begin
      send_bits(d[i], 8, rb);
`ifdef VSLC_PROG_READBACK_EN
      chk("readback", rb, model[p]);
`else
      chk("miso_tied", rb, 8'h00);
`endif
      model[p] = d[i];
      p = (p + 1) % 32;
    end
    ld_cs_n = 1'b1;
    cyc(6);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bytes [$];
    logic [7:0] rb;
    int n;

    foreach (model[i]) model[i] = 8'h00;

    cyc(3);
    rst_n = 1'b1;
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_rvalid", {7'd0, rvalid}, 8'h00);
    chk("rst_hold", {7'd0, hold_core}, 8'h00);
    chk("rst_miso", {7'd0, ld_miso}, 8'h00);
    cyc(4);
    fetch(8'h03);

    // Single write with hold_core edge timing.
    ld_cs_n = 1'b0;
    cyc(2);
    chk("hold_rise_early", {7'd0, hold_core}, 8'h00);
    cyc(1);
    chk("hold_rise", {7'd0, hold_core}, 8'h01);
    cyc(3);
    send_bits(8'h05, 8, rb);
    send_bits(8'hA7, 8, rb);
    chk("hold_mid", {7'd0, hold_core}, 8'h01);
    model[5] = 8'hA7;
    ld_cs_n = 1'b1;
    cyc(2);
    chk("hold_fall_early", {7'd0, hold_core}, 8'h01);
    cyc(1);
    chk("hold_fall", {7'd0, hold_core}, 8'h00);
    cyc(3);
    fetch(8'h05);

    // Pointer wrap and out-of-range fetch.
    bytes = {8'h11, 8'h22};
    load(8'h1F, bytes);
    fetch(8'h1F);
    fetch(8'h00);
    fetch(8'h20);

    // Aborted partial byte leaves memory untouched; next frame writes normally.
    ld_cs_n = 1'b0;
    cyc(6);
    send_bits(8'h02, 8, rb);
    send_bits(8'hFF, 5, rb);
    ld_cs_n = 1'b1;
    cyc(6);
    fetch(8'h02);
    bytes = {8'h5A};
    load(8'h02, bytes);
    fetch(8'h02);

    // Back-to-back strobes.
    bytes = {8'h10, 8'h11, 8'h12, 8'h13};
    load(8'h00, bytes);
    for (int i = 0; i < 4; i++) begin
      addr = 8'(i);
      addr_strobe = 1'b1;
      exp_q.push_back(exp_of(8'(i)));
      cyc(1);
      chk("burst_rvalid", {7'd0, rvalid}, 8'h01);
    end
    addr_strobe = 1'b0;
    cyc(2);

    // Readback of old contents while writing new ones.
    bytes = {8'h3C};
    load(8'h04, bytes);
    bytes = {8'hC3, 8'h77};
    load(8'h04, bytes);
    fetch(8'h04);
    fetch(8'h05);

    // Random frames (upper address bits must be ignored) and random fetches.
    for (int f = 0; f < 6; f++) begin
      bytes = {};
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) bytes.push_back(8'($urandom_range(0, 255)));
      load(8'($urandom_range(0, 255)), bytes);
    end
    for (int k = 0; k < 24; k++) fetch(8'($urandom_range(0, 63)));

    // Reset mid-frame: memory cleared, remainder of frame ignored.
    ld_cs_n = 1'b0;
    cyc(6);
    send_bits(8'h07, 8, rb);
    send_bits(8'h55, 4, rb);
    rst_n = 1'b0;
    cyc(2);
    foreach (model[i]) model[i] = 8'h00;
    chk("rst_mid_hold", {7'd0, hold_core}, 8'h00);
    rst_n = 1'b1;
    cyc(1);
    send_bits(8'h55, 8, rb);
    send_bits(8'h99, 8, rb);
    chk("post_rst_hold", {7'd0, hold_core}, 8'h00);
    ld_cs_n = 1'b1;
    cyc(6);
    for (int k = 0; k < 32; k++) fetch(8'(k));

    // Fresh frame after reset still works.
    bytes = {8'hE1};
    load(8'h07, bytes);
    fetch(8'h07);

    cyc(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL outstanding_fetches: %0d left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
